// File: rtl/vc_fifo_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : vc_fifo_bank_if
// Purpose  : Write/read handshake, threshold and status bundle for vc_fifo_bank.
// Revision : 1.0
// ============================================================================
interface vc_fifo_bank_if #(
  parameter int BW     = 6,
  parameter int NUM_VC = 2,
  parameter int VC_W   = 1,
  parameter int PTR    = 4
);
  logic                        wr_en;
  logic [VC_W-1:0]             wr_vc;
  logic [BW-1:0]               wr_data;
  logic [NUM_VC-1:0]           rd_en;
  logic [NUM_VC*(PTR+1)-1:0]   umbral_bajo;
  logic [NUM_VC*(PTR+1)-1:0]   umbral_alto;
  logic [NUM_VC*BW-1:0]        rd_data;
  logic [NUM_VC-1:0]           rd_valid;
  logic [NUM_VC-1:0]           fifo_full;
  logic [NUM_VC-1:0]           fifo_empty;
  logic [NUM_VC-1:0]           almost_full;
  logic [NUM_VC-1:0]           almost_empty;
  logic [NUM_VC-1:0]           error_output;
  logic [NUM_VC*(PTR+1)-1:0]   fifo_count;
  logic                        wr_drop;

  modport master (
    output wr_en, wr_vc, wr_data, rd_en, umbral_bajo, umbral_alto,
    input  rd_data, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
           error_output, fifo_count, wr_drop
  );

  modport slave (
    input  wr_en, wr_vc, wr_data, rd_en, umbral_bajo, umbral_alto,
    output rd_data, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
           error_output, fifo_count, wr_drop
  );
endinterface
`default_nettype wire

// File: rtl/vc_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : vc_fifo_bank
// Purpose  : NUM_VC independent FIFOs behind one VC-steered write port.
// Revision : 1.0
// ============================================================================
module vc_fifo_bank #(
  parameter int BW     = 6,
  parameter int NUM_VC = 2,
  parameter int VC_W   = 1,
  parameter int DEPTH  = 16,
  parameter int PTR    = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  vc_fifo_bank_if.slave bus
);
  localparam int            CW      = PTR + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [NUM_VC-1:0] wr_hit;
  logic [NUM_VC-1:0] wr_ovf;
  logic              wr_drop_d;
  logic              wr_drop_q;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    logic [BW-1:0]  mem_q [DEPTH];
    logic [PTR-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [BW-1:0]  rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           err_q, err_d;
    logic           full, empty, wr_acc, rd_acc;

    assign wr_hit[i] = bus.wr_en && (bus.wr_vc == VC_W'(i));
    assign wr_ovf[i] = wr_hit[i] && full && !bus.rd_en[i];

    always_comb begin
      full       = (count_q == C_DEPTH);
      empty      = (count_q == '0);
      // A read frees a slot this cycle, so a write to a full channel still lands
      wr_acc     = wr_hit[i] && (!full || bus.rd_en[i]);
      rd_acc     = bus.rd_en[i] && !empty;
      wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
      rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
      rd_valid_d = rd_acc;
      err_d      = err_q || wr_ovf[i] || (bus.rd_en[i] && empty);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        count_q    <= count_d;
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
        err_q      <= err_d;
      end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.rd_data[i*BW +: BW]    = rd_data_q;
    assign bus.rd_valid[i]            = rd_valid_q;
    assign bus.fifo_full[i]           = full;
    assign bus.fifo_empty[i]          = empty;
    assign bus.almost_full[i]         = (count_q >= bus.umbral_alto[i*CW +: CW]);
    assign bus.almost_empty[i]        = (count_q <= bus.umbral_bajo[i*CW +: CW]);
    assign bus.error_output[i]        = err_q;
    assign bus.fifo_count[i*CW +: CW] = count_q;
  end

  // Out-of-range VC hits no channel, so it shows up as an empty hit vector
  assign wr_drop_d = bus.wr_en && (!(|wr_hit) || (|wr_ovf));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_drop_q <= 1'b0;
    else       wr_drop_q <= wr_drop_d;
  end

  assign bus.wr_drop = wr_drop_q;
endmodule
`default_nettype wire

// File: tb/tb_vc_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_fifo_bank
// Purpose  : Randomised and directed checks of vc_fifo_bank against a queue model.
// Revision : 1.0
// ============================================================================
module tb_vc_fifo_bank;
  localparam int BW = 6, NV = 2, VW = 2, DEPTH = 16, PTR = 4, CW = PTR + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vc_fifo_bank_if #(.BW(BW), .NUM_VC(NV), .VC_W(VW), .PTR(PTR)) bus ();

  vc_fifo_bank #(.BW(BW), .NUM_VC(NV), .VC_W(VW), .DEPTH(DEPTH), .PTR(PTR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] mq0[$];
  logic [BW-1:0] mq1[$];
  logic [BW-1:0] m_data [NV];
  bit            m_valid[NV];
  bit            m_err  [NV];
  bit            m_drop;
  logic [CW-1:0] ua[NV];
  logic [CW-1:0] ub[NV];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int c);
    return (c == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic set_thr(input int c, input logic [CW-1:0] lo, input logic [CW-1:0] hi);
    ub[c] = lo;
    ua[c] = hi;
    bus.umbral_bajo = {ub[1], ub[0]};
    bus.umbral_alto = {ua[1], ua[0]};
  endtask

  task automatic compare();
    int n;
    for (int c = 0; c < NV; c++) begin
      n = qsize(c);
      chk($sformatf("count%0d", c), 32'(bus.fifo_count[c*CW +: CW]), 32'(n));
      chk($sformatf("full%0d", c),  32'(bus.fifo_full[c]),    32'(n == DEPTH));
      chk($sformatf("empty%0d", c), 32'(bus.fifo_empty[c]),   32'(n == 0));
      chk($sformatf("afull%0d", c), 32'(bus.almost_full[c]),  32'(n >= int'(ua[c])));
      chk($sformatf("aempty%0d", c),32'(bus.almost_empty[c]), 32'(n <= int'(ub[c])));
      chk($sformatf("valid%0d", c), 32'(bus.rd_valid[c]),     32'(m_valid[c]));
      chk($sformatf("data%0d", c),  32'(bus.rd_data[c*BW +: BW]), 32'(m_data[c]));
      chk($sformatf("err%0d", c),   32'(bus.error_output[c]), 32'(m_err[c]));
    end
    chk("drop", 32'(bus.wr_drop), 32'(m_drop));
  endtask

  // One clock: apply inputs, advance the model by the queue rules, check after the edge
  task automatic cyc(input bit we, input logic [VW-1:0] vc, input logic [BW-1:0] d,
                     input logic [NV-1:0] re);
    int n;
    bit wsel, wa, ra;
    bus.wr_en   = we;
    bus.wr_vc   = vc;
    bus.wr_data = d;
    bus.rd_en   = re;
    m_drop = 1'b0;
    for (int c = 0; c < NV; c++) begin
      n    = qsize(c);
      wsel = we && (int'(vc) == c);
      wa   = wsel && (n < DEPTH || re[c]);
      ra   = re[c] && (n > 0);
      if (wsel && n == DEPTH && !re[c]) begin
        m_err[c] = 1'b1;
        m_drop   = 1'b1;
      end
      if (re[c] && n == 0) m_err[c] = 1'b1;
      m_valid[c] = ra;
      if (ra) m_data[c] = (c == 0) ? mq0.pop_front() : mq1.pop_front();
      if (wa) begin
        if (c == 0) mq0.push_back(d);
        else        mq1.push_back(d);
      end
    end
    if (we && int'(vc) >= NV) m_drop = 1'b1;
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    bus.wr_en = 1'b0;
    bus.rd_en = '0;
    reset = 1'b1;
    #2;
    mq0.delete();
    mq1.delete();
    for (int c = 0; c < NV; c++) begin
      m_data[c]  = '0;
      m_valid[c] = 1'b0;
      m_err[c]   = 1'b0;
    end
    m_drop = 1'b0;
    compare();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_vc = '0;
    bus.wr_data = '0;
    bus.rd_en = '0;
    set_thr(0, 5'd2, 5'd14);
    set_thr(1, 5'd2, 5'd14);
    #1;
    do_reset();
    cyc(1'b0, 2'd0, 6'd0, 2'b00);

    // Fill VC1 with 1..16 and drain it in order
    for (int k = 1; k <= 16; k++) cyc(1'b1, 2'd1, BW'(k), 2'b00);
    for (int k = 0; k < 16; k++)  cyc(1'b0, 2'd0, 6'd0, 2'b10);
    cyc(1'b0, 2'd0, 6'd0, 2'b00);

    // VC0 to full, overflow, then read+write at full
    for (int k = 0; k < 17; k++) cyc(1'b1, 2'd0, BW'(k + 20), 2'b00);
    cyc(1'b1, 2'd0, 6'h3F, 2'b01);
    cyc(1'b0, 2'd0, 6'd0, 2'b00);
    do_reset();

    // Almost-empty threshold and underflow on VC1
    for (int k = 0; k < 3; k++) cyc(1'b1, 2'd1, BW'(k + 7), 2'b00);
    for (int k = 0; k < 4; k++) cyc(1'b0, 2'd0, 6'd0, 2'b10);
    // Empty with simultaneous read and write on VC0
    cyc(1'b1, 2'd0, 6'h15, 2'b01);

    // Out-of-range channel index
    cyc(1'b1, 2'd3, 6'h11, 2'b00);
    cyc(1'b1, 2'd2, 6'h12, 2'b00);

    // Reset mid-stream discards queued data
    for (int k = 0; k < 5; k++) cyc(1'b1, 2'd0, BW'(k + 1), 2'b00);
    do_reset();
    cyc(1'b1, 2'd0, 6'h2A, 2'b00);
    cyc(1'b0, 2'd0, 6'd0, 2'b01);
    cyc(1'b0, 2'd0, 6'd0, 2'b00);

    // Random traffic with moving thresholds and occasional resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 29) == 0)
        set_thr(int'($urandom_range(0, 1)), CW'($urandom_range(0, 16)), CW'($urandom_range(0, 17)));
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc(bit'($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) == 0) ? VW'($urandom_range(2, 3)) : VW'($urandom_range(0, 1)),
          BW'($urandom),
          NV'($urandom_range(0, 3) & $urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
